// File: rtl/spi_sd_responder.sv
// SPI-mode microSD card responder: decodes 48-bit command frames, returns R1 or R1+32 responses.
// Optional build macro SPI_SDRSP_CRC_EN adds CRC7 checking with an automatic 0x08 reply on mismatch.
module spi_sd_responder #(
  parameter int NCR_MAX_BYTES = 8
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        SCK_SPI,
  input  logic        SS,
  input  logic        MOSI,
  output logic        MISO,
  output logic        spi_misooe_o,
  output logic [5:0]  spi_cmd_o,
  output logic [31:0] spi_arg_o,
  output logic        spi_cmdvalid_o,
  output logic        spi_rspready_o,
  input  logic        spi_rspvalid_i,
  input  logic [7:0]  spi_r1_i,
  input  logic [31:0] spi_rspdata_i,
  input  logic        spi_rsplong_i,
  output logic        spi_ncrtimeout_o,
  output logic        spi_frameerr_o
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_HUNT = 3'd1;
  localparam logic [2:0] ST_RECV = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_SEND = 3'd4;
  localparam logic [3:0] NCR_LIM = 4'(NCR_MAX_BYTES);

  logic [2:0]  sck_sync_q;
  logic [1:0]  ss_sync_q, mosi_sync_q;
  logic        sck_rise_s, sck_fall_s, ss_s, mosi_s, hs_s, crc_ok_s;
  logic [2:0]  state_q, state_d;
  logic [5:0]  bitcnt_q, bitcnt_d;
  logic [3:0]  bytes_q, bytes_d;
  logic [45:0] frame_q, frame_d;
  logic [39:0] shreg_q, shreg_d;
  logic        long_q, long_d, loaded_q, loaded_d;
  logic        miso_q, miso_d, oe_q;
  logic        cmdvalid_q, cmdvalid_d, frameerr_q, frameerr_d;
  logic        rspready_q, rspready_d, ncrto_q, ncrto_d;
  logic [5:0]  cmd_q, cmd_d;
  logic [31:0] arg_q, arg_d;

`ifdef SPI_SDRSP_CRC_EN
  logic [6:0] crc_q, crc_d;

  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = crc[6] ^ din;
    crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_ok_s = (crc_q == frame_q[6:0]);
`else
  assign crc_ok_s = 1'b1;
`endif

  assign sck_rise_s = sck_sync_q[1] & ~sck_sync_q[2];
  assign sck_fall_s = ~sck_sync_q[1] & sck_sync_q[2];
  assign ss_s       = ss_sync_q[1];
  assign mosi_s     = mosi_sync_q[1];
  assign hs_s       = rspready_q & spi_rspvalid_i;

  // Next-state logic for the frame receiver, Ncr wait and response shifter.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    bytes_d    = bytes_q;
    frame_d    = frame_q;
    shreg_d    = shreg_q;
    long_d     = long_q;
    loaded_d   = loaded_q;
    miso_d     = miso_q;
    cmdvalid_d = 1'b0;
    frameerr_d = 1'b0;
    ncrto_d    = ncrto_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
`ifdef SPI_SDRSP_CRC_EN
    crc_d      = crc_q;
`endif
    if (ss_s) begin
      state_d  = ST_IDLE;
      miso_d   = 1'b1;
      loaded_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_HUNT;
          miso_d  = 1'b1;
        end
        ST_HUNT: begin
          if (sck_rise_s && !mosi_s) begin
            state_d  = ST_RECV;
            bitcnt_d = 6'd0;
`ifdef SPI_SDRSP_CRC_EN
            crc_d    = 7'd0;
`endif
          end else begin
            state_d = ST_HUNT;
          end
        end
        ST_RECV: begin
          if (sck_rise_s) begin
            frame_d = {frame_q[44:0], mosi_s};
`ifdef SPI_SDRSP_CRC_EN
            if (bitcnt_q < 6'd39) crc_d = crc7_step(crc_q, mosi_s);
            else crc_d = crc_q;
`endif
            if (bitcnt_q == 6'd46) begin
              bitcnt_d = 6'd0;
              bytes_d  = 4'd0;
              // frame_q holds bits 46..1 here; the end bit is the live sample
              if (!frame_q[45] || !mosi_s) begin
                frameerr_d = 1'b1;
                state_d    = ST_HUNT;
              end else if (crc_ok_s) begin
                cmd_d      = frame_q[44:39];
                arg_d      = frame_q[38:7];
                cmdvalid_d = 1'b1;
                loaded_d   = 1'b0;
                state_d    = ST_WAIT;
              end else begin
                shreg_d  = {8'h08, 32'hFFFF_FFFF};
                long_d   = 1'b0;
                loaded_d = 1'b1;
                state_d  = ST_WAIT;
              end
            end else begin
              bitcnt_d = bitcnt_q + 6'd1;
            end
          end else begin
            frame_d = frame_q;
          end
        end
        ST_WAIT: begin
          miso_d = 1'b1;
          if (hs_s) begin
            shreg_d  = spi_rsplong_i ? {spi_r1_i, spi_rspdata_i} : {spi_r1_i, 32'hFFFF_FFFF};
            long_d   = spi_rsplong_i;
            loaded_d = 1'b1;
          end else begin
            shreg_d = shreg_q;
          end
          if (sck_rise_s) begin
            if (bitcnt_q[2:0] == 3'd7) begin
              bitcnt_d = 6'd0;
              // a handshake arriving on the boundary itself still beats the timeout
              if (loaded_q || hs_s) begin
                state_d  = ST_SEND;
                bitcnt_d = long_d ? 6'd40 : 6'd8;
              end else if ((bytes_q + 4'd1) == NCR_LIM) begin
                ncrto_d = 1'b1;
                state_d = ST_HUNT;
              end else begin
                bytes_d = bytes_q + 4'd1;
              end
            end else begin
              bitcnt_d = bitcnt_q + 6'd1;
            end
          end else begin
            bitcnt_d = bitcnt_q;
          end
        end
        ST_SEND: begin
          if (sck_fall_s) begin
            miso_d  = shreg_q[39];
            shreg_d = {shreg_q[38:0], 1'b1};
          end else if (sck_rise_s) begin
            if (bitcnt_q == 6'd1) begin
              state_d  = ST_HUNT;
              miso_d   = 1'b1;
              bitcnt_d = 6'd0;
              loaded_d = 1'b0;
            end else begin
              bitcnt_d = bitcnt_q - 6'd1;
            end
          end else begin
            shreg_d = shreg_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          miso_d  = 1'b1;
        end
      endcase
    end
    rspready_d = (state_q == ST_WAIT) && (state_d == ST_WAIT) && !loaded_d;
  end

  // Pin synchronisers and all state/output registers.
  always_ff @(posedge spi_clk_i) begin
    if (spi_rst_i) begin
      sck_sync_q  <= 3'b000;
      ss_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b11;
      state_q     <= ST_IDLE;
      bitcnt_q    <= 6'd0;
      bytes_q     <= 4'd0;
      frame_q     <= 46'd0;
      shreg_q     <= 40'hFF_FFFF_FFFF;
      long_q      <= 1'b0;
      loaded_q    <= 1'b0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      cmdvalid_q  <= 1'b0;
      frameerr_q  <= 1'b0;
      rspready_q  <= 1'b0;
      ncrto_q     <= 1'b0;
      cmd_q       <= 6'd0;
      arg_q       <= 32'd0;
`ifdef SPI_SDRSP_CRC_EN
      crc_q       <= 7'd0;
`endif
    end else begin
      sck_sync_q  <= {sck_sync_q[1:0], SCK_SPI};
      ss_sync_q   <= {ss_sync_q[0], SS};
      mosi_sync_q <= {mosi_sync_q[0], MOSI};
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      bytes_q     <= bytes_d;
      frame_q     <= frame_d;
      shreg_q     <= shreg_d;
      long_q      <= long_d;
      loaded_q    <= loaded_d;
      miso_q      <= miso_d;
      oe_q        <= ~ss_s;
      cmdvalid_q  <= cmdvalid_d;
      frameerr_q  <= frameerr_d;
      rspready_q  <= rspready_d;
      ncrto_q     <= ncrto_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
`ifdef SPI_SDRSP_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign MISO             = miso_q;
  assign spi_misooe_o     = oe_q;
  assign spi_cmd_o        = cmd_q;
  assign spi_arg_o        = arg_q;
  assign spi_cmdvalid_o   = cmdvalid_q;
  assign spi_rspready_o   = rspready_q;
  assign spi_ncrtimeout_o = ncrto_q;
  assign spi_frameerr_o   = frameerr_q;

endmodule

// File: tb/tb_spi_sd_responder.sv
// Directed bench for spi_sd_responder: host-side SPI driver at SCK = clk/8 with a MISO byte scoreboard.
module tb_spi_sd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sck, ss, mosi, miso, misooe;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        cmdvalid, rspready, rspvalid, rsplong, ncrto, frameerr;
  logic [7:0]  r1;
  logic [31:0] rspdata;

  int checks = 0;
  int errors = 0;
  int cv_cnt = 0;
  int fe_cnt = 0;
  int cv0, fe0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  spi_sd_responder #(.NCR_MAX_BYTES(8)) dut (
    .spi_clk_i        (clk),
    .spi_rst_i        (rst),
    .SCK_SPI          (sck),
    .SS               (ss),
    .MOSI             (mosi),
    .MISO             (miso),
    .spi_misooe_o     (misooe),
    .spi_cmd_o        (cmd),
    .spi_arg_o        (arg),
    .spi_cmdvalid_o   (cmdvalid),
    .spi_rspready_o   (rspready),
    .spi_rspvalid_i   (rspvalid),
    .spi_r1_i         (r1),
    .spi_rspdata_i    (rspdata),
    .spi_rsplong_i    (rsplong),
    .spi_ncrtimeout_o (ncrto),
    .spi_frameerr_o   (frameerr)
  );

  // Pulse counters: a pulse held for two cycles shows up as two.
  always @(posedge clk) begin
    if (cmdvalid) cv_cnt <= cv_cnt + 1;
    if (frameerr) fe_cnt <= fe_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Mode 0 host: MOSI set while SCK low, MISO sampled at the rising edge.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      sck = 1'b1;
      rx[i] = miso;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  task automatic host_byte(input logic [7:0] tx);
    logic [7:0] rx, expv;
    xfer(tx, rx);
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check("miso_byte", {24'd0, rx}, {24'd0, expv});
  endtask

  task automatic send_frame(input logic [47:0] f);
    for (int k = 5; k >= 0; k--) begin
      exp_q.push_back(8'hFF);
      host_byte(f[8*k +: 8]);
    end
  endtask

  task automatic read_bytes(input int n);
    for (int k = 0; k < n; k++) host_byte(8'hFF);
  endtask

  task automatic offer(input logic [7:0] r, input logic lng, input logic [31:0] d);
    r1 = r; rsplong = lng; rspdata = d; rspvalid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; sck = 1'b0; ss = 1'b1; mosi = 1'b1;
    rspvalid = 1'b0; r1 = 8'h00; rspdata = 32'd0; rsplong = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_miso", {31'd0, miso}, 32'd1);
    check("rst_oe", {31'd0, misooe}, 32'd0);
    check("rst_cmd", {26'd0, cmd}, 32'd0);
    check("rst_arg", arg, 32'd0);
    check("rst_cmdvalid", {31'd0, cmdvalid}, 32'd0);
    check("rst_rspready", {31'd0, rspready}, 32'd0);
    check("rst_ncrto", {31'd0, ncrto}, 32'd0);
    check("rst_frameerr", {31'd0, frameerr}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b0;
    repeat (6) @(negedge clk);
    check("oe_selected", {31'd0, misooe}, 32'd1);

    // CMD0, short R1 0x01
    offer(8'h01, 1'b0, 32'd0);
    cv0 = cv_cnt;
    send_frame(48'h40_00_00_00_00_95);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    read_bytes(2);
    rspvalid = 1'b0;
    check("cmd0_pulses", cv_cnt - cv0, 32'd1);
    check("cmd0_cmd", {26'd0, cmd}, 32'd0);
    check("cmd0_arg", arg, 32'd0);
    check("cmd0_rspready_low", {31'd0, rspready}, 32'd0);

    // CMD8, long R7
    offer(8'h01, 1'b1, 32'h0000_01AA);
    cv0 = cv_cnt;
    send_frame(48'h48_00_00_01_AA_87);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01); exp_q.push_back(8'h00);
    exp_q.push_back(8'h00); exp_q.push_back(8'h01); exp_q.push_back(8'hAA);
    read_bytes(6);
    rspvalid = 1'b0;
    check("cmd8_pulses", cv_cnt - cv0, 32'd1);
    check("cmd8_cmd", {26'd0, cmd}, 32'd8);
    check("cmd8_arg", arg, 32'h0000_01AA);

    // CMD0 unanswered: Ncr timeout after 8 bytes
    send_frame(48'h40_00_00_00_00_95);
    repeat (2) @(negedge clk);
    check("wait_rspready", {31'd0, rspready}, 32'd1);
    check("wait_no_timeout", {31'd0, ncrto}, 32'd0);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'hFF);
    read_bytes(8);
    check("ncr_timeout", {31'd0, ncrto}, 32'd1);
    check("timeout_rspready", {31'd0, rspready}, 32'd0);

    // CMD17 still decodes after the timeout
    offer(8'h00, 1'b0, 32'd0);
    cv0 = cv_cnt;
    send_frame(48'h51_00_00_00_00_55);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    read_bytes(2);
    rspvalid = 1'b0;
    check("cmd17_pulses", cv_cnt - cv0, 32'd1);
    check("cmd17_cmd", {26'd0, cmd}, 32'd17);

    // SS raised after 20 bits of CMD0
    cv0 = cv_cnt; fe0 = fe_cnt;
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    host_byte(8'h40);
    host_byte(8'h00);
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b0;
      repeat (4) @(negedge clk);
      sck = 1'b1;
      repeat (4) @(negedge clk);
      sck = 1'b0;
    end
    ss = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_cmdvalid", cv_cnt - cv0, 32'd0);
    check("abort_frameerr", fe_cnt - fe0, 32'd0);
    check("abort_oe", {31'd0, misooe}, 32'd0);
    check("abort_miso", {31'd0, miso}, 32'd1);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    offer(8'h01, 1'b0, 32'd0);
    send_frame(48'h40_00_00_00_00_95);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    read_bytes(2);
    rspvalid = 1'b0;
    check("after_abort_pulses", cv_cnt - cv0, 32'd1);
    check("after_abort_cmd", {26'd0, cmd}, 32'd0);

    // End bit cleared: framing error, no command
    cv0 = cv_cnt; fe0 = fe_cnt;
    send_frame(48'h40_00_00_00_00_94);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    read_bytes(2);
    check("badend_frameerr", fe_cnt - fe0, 32'd1);
    check("badend_cmdvalid", cv_cnt - cv0, 32'd0);
    check("badend_rspready", {31'd0, rspready}, 32'd0);
    check("badend_miso", {31'd0, miso}, 32'd1);

    // CMD0 with a wrong CRC byte
    cv0 = cv_cnt;
`ifdef SPI_SDRSP_CRC_EN
    send_frame(48'h40_00_00_00_00_97);
    repeat (2) @(negedge clk);
    check("crcerr_rspready", {31'd0, rspready}, 32'd0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h08);
    read_bytes(2);
    check("crcerr_cmdvalid", cv_cnt - cv0, 32'd0);
`else
    offer(8'h01, 1'b0, 32'd0);
    send_frame(48'h40_00_00_00_00_97);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    read_bytes(2);
    rspvalid = 1'b0;
    check("nocrc_cmdvalid", cv_cnt - cv0, 32'd1);
    check("nocrc_cmd", {26'd0, cmd}, 32'd0);
`endif
    check("ncrto_sticky", {31'd0, ncrto}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
